// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back arbiter.
// Request payload, grant source encoding, starvation limit default.
package wb_pkg;

   localparam int WB_DATA_W       = 32;
   localparam int WB_ADDR_W       = 5;
   localparam int WB_STARVE_LIMIT = 4;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_MEM
   } wb_src_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding slot for a write-back request; writes to x0 are accepted and dropped.
// Fills on the accept edge; ready while empty or draining, low during reset.
module wb_hold_slot
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   output logic                  ready,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  drain,
   output logic                  full,
   output logic [ADDR_WIDTH-1:0] q_rd,
   output logic [DATA_WIDTH-1:0] q_data
);

   logic fill;

   assign ready = !rst && (!full || drain);
   assign fill  = valid && ready && (rd != '0);

   // A refill in the draining cycle wins over the drain, so the slot stays full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full   <= 1'b0;
         q_rd   <= '0;
         q_data <= '0;
      end else if (fill) begin
         full   <= 1'b1;
         q_rd   <= rd;
         q_data <= data;
      end else if (drain) begin
         full   <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and memory write-back requests onto the single register-file write port.
// Accept-to-we3 latency one cycle; memory has priority until the ALU has lost STARVE_LIMIT times.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] ad3,
   output logic                  we3,
   output logic [DATA_WIDTH-1:0] wd3,
   output logic [31:0]           pend_mask
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic                  alu_full, mem_full;
   logic [ADDR_WIDTH-1:0] alu_q_rd, mem_q_rd;
   logic [DATA_WIDTH-1:0] alu_q_data, mem_q_data;
   logic [SW-1:0]         starve;
   wb_src_t               grant;

   wb_hold_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_alu_slot (
      .clk    (clk),
      .rst    (rst),
      .valid  (alu_valid),
      .ready  (alu_ready),
      .rd     (alu_rd),
      .data   (alu_data),
      .drain  (grant == WB_ALU),
      .full   (alu_full),
      .q_rd   (alu_q_rd),
      .q_data (alu_q_data)
   );

   wb_hold_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem_slot (
      .clk    (clk),
      .rst    (rst),
      .valid  (mem_valid),
      .ready  (mem_ready),
      .rd     (mem_rd),
      .data   (mem_data),
      .drain  (grant == WB_MEM),
      .full   (mem_full),
      .q_rd   (mem_q_rd),
      .q_data (mem_q_data)
   );

   // Grant looks only at slot state, so ready never depends on valid.
   always_comb begin
      grant = WB_NONE;
      if (mem_full && (starve < LIMIT))
         grant = WB_MEM;
      else if (alu_full && (!mem_full || (starve == LIMIT)))
         grant = WB_ALU;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve <= '0;
      end else if ((grant == WB_ALU) || !alu_full) begin
         starve <= '0;
      end else if ((grant == WB_MEM) && (starve < LIMIT)) begin
         starve <= starve + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we3 <= 1'b0;
         ad3 <= '0;
         wd3 <= '0;
      end else begin
         case (grant)
            WB_MEM: begin
               we3 <= 1'b1;
               ad3 <= DATA_WIDTH'(mem_q_rd);
               wd3 <= mem_q_data;
            end
            WB_ALU: begin
               we3 <= 1'b1;
               ad3 <= DATA_WIDTH'(alu_q_rd);
               wd3 <= alu_q_data;
            end
            default: we3 <= 1'b0;
         endcase
      end
   end

   // Slots never hold x0, so bit 0 stays clear without a special case.
   always_comb begin
      pend_mask = '0;
      for (int i = 1; i < 32; i++) begin
         if ((alu_full && (alu_q_rd == ADDR_WIDTH'(i))) ||
             (mem_full && (mem_q_rd == ADDR_WIDTH'(i))) ||
             (we3 && (ad3[ADDR_WIDTH-1:0] == ADDR_WIDTH'(i))))
            pend_mask[i] = 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, x0 drop, contention, starvation, reset mid-flight.
module tb_wb_arbiter;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd, mem_rd;
   logic [31:0] alu_data, mem_data;
   logic [31:0] ad3, wd3, pend_mask;
   logic        we3;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int stall_cnt = 0;

   wb_req_t wlog[$];
   int      wcyc[$];
   wb_req_t exp_q[$];

   wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .ad3       (ad3),
      .we3       (we3),
      .wd3       (wd3),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we3 === 1'b1) begin
         wlog.push_back('{rd: ad3[4:0], data: wd3});
         wcyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input bit is_mem, input logic [4:0] rd, input logic [31:0] d);
      int k = 0;
      if (is_mem) begin
         mem_valid = 1'b1; mem_rd = rd; mem_data = d;
      end else begin
         alu_valid = 1'b1; alu_rd = rd; alu_data = d;
      end
      while (((is_mem ? mem_ready : alu_ready) !== 1'b1) && (k < 50)) begin
         @(negedge clk);
         k++;
      end
      if (k > 0) stall_cnt++;
      check_eq(is_mem ? "mem_ready_wait" : "alu_ready_wait",
               32'(is_mem ? mem_ready : alu_ready), 32'd1);
      @(negedge clk);
      if (is_mem) mem_valid = 1'b0;
      else        alu_valid = 1'b0;
   endtask

   task automatic check_log(input string tag);
      check_eq({tag, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
         check_eq($sformatf("%s_rd%0d", tag, i), 32'(wlog[i].rd), 32'(exp_q[i].rd));
         check_eq($sformatf("%s_data%0d", tag, i), wlog[i].data, exp_q[i].data);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      #2;
      check_eq("rst_we3", 32'(we3), 32'd0);
      check_eq("rst_ad3", ad3, 32'd0);
      check_eq("rst_wd3", wd3, 32'd0);
      check_eq("rst_pend", pend_mask, 32'd0);
      check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
      check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rel_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("rel_mem_ready", 32'(mem_ready), 32'd1);
      @(negedge clk);

      // Single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1 check_eq("t1_alu_ready", 32'(alu_ready), 32'd1);
      @(negedge clk);
      alu_valid = 1'b0;
      check_eq("t1_pend_acc", pend_mask, 32'h0000_0020);
      check_eq("t1_we3_acc", 32'(we3), 32'd0);
      @(negedge clk);
      check_eq("t1_we3", 32'(we3), 32'd1);
      check_eq("t1_ad3", ad3, 32'd5);
      check_eq("t1_wd3", wd3, 32'hDEADBEEF);
      check_eq("t1_pend_wr", pend_mask, 32'h0000_0020);
      @(negedge clk);
      check_eq("t1_we3_off", 32'(we3), 32'd0);
      check_eq("t1_pend_off", pend_mask, 32'd0);
      check_eq("t1_ad3_hold", ad3, 32'd5);
      check_eq("t1_wd3_hold", wd3, 32'hDEADBEEF);

      // Write to x0 from memory is accepted and dropped
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
      #1 check_eq("x0_mem_ready", 32'(mem_ready), 32'd1);
      @(negedge clk);
      mem_valid = 1'b0;
      check_eq("x0_pend_acc", pend_mask, 32'd0);
      check_eq("x0_we3_acc", 32'(we3), 32'd0);
      @(negedge clk);
      check_eq("x0_we3", 32'(we3), 32'd0);
      check_eq("x0_pend", pend_mask, 32'd0);
      check_eq("x0_wd3_hold", wd3, 32'hDEADBEEF);

      // Simultaneous handshake: memory first, then ALU
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
      #1;
      check_eq("sim_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("sim_mem_ready", 32'(mem_ready), 32'd1);
      @(negedge clk);
      alu_valid = 1'b0; mem_valid = 1'b0;
      check_eq("sim_pend", pend_mask, 32'h0000_0018);
      @(negedge clk);
      check_eq("sim_we3_a", 32'(we3), 32'd1);
      check_eq("sim_ad3_a", ad3, 32'd4);
      check_eq("sim_wd3_a", wd3, 32'hB);
      @(negedge clk);
      check_eq("sim_we3_b", 32'(we3), 32'd1);
      check_eq("sim_ad3_b", ad3, 32'd3);
      check_eq("sim_wd3_b", wd3, 32'hA);
      @(negedge clk);
      check_eq("sim_we3_off", 32'(we3), 32'd0);
      check_eq("sim_pend_off", pend_mask, 32'd0);

      // Starvation: memory streams, ALU wins on the 5th arbitration
      @(negedge clk);
      wlog.delete(); wcyc.delete(); exp_q.delete();
      fork
         send(1'b0, 5'd7, 32'h77);
         for (int i = 0; i < 6; i++) send(1'b1, 5'(10 + i), 32'h100 + i);
      join
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back('{rd: 5'(10 + i), data: 32'h100 + i});
      exp_q.push_back('{rd: 5'd7, data: 32'h77});
      exp_q.push_back('{rd: 5'd14, data: 32'h104});
      exp_q.push_back('{rd: 5'd15, data: 32'h105});
      check_log("starve");
      if (wcyc.size() == 7) check_eq("starve_span", 32'(wcyc[6] - wcyc[0]), 32'd6);
      else check_eq("starve_span_count", 32'(wcyc.size()), 32'd7);

      // Back-to-back ALU rd 1..8
      wlog.delete(); wcyc.delete(); exp_q.delete();
      stall_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         send(1'b0, 5'(i), 32'h1000 * i);
         exp_q.push_back('{rd: 5'(i), data: 32'h1000 * i});
      end
      repeat (3) @(negedge clk);
      check_eq("b2b_stalls", 32'(stall_cnt), 32'd0);
      check_log("b2b");
      if (wcyc.size() == 8) check_eq("b2b_span", 32'(wcyc[7] - wcyc[0]), 32'd7);
      else check_eq("b2b_span_count", 32'(wcyc.size()), 32'd8);

      // Reset mid-flight with both slots full and a write on the port
      alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
      mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAA;
      @(negedge clk);
      alu_valid = 1'b0;
      mem_rd = 5'd11; mem_data = 32'hBB;
      #1 check_eq("mid_mem_refill_ready", 32'(mem_ready), 32'd1);
      @(negedge clk);
      mem_valid = 1'b0;
      check_eq("mid_we3", 32'(we3), 32'd1);
      check_eq("mid_ad3", ad3, 32'd10);
      check_eq("mid_pend", pend_mask, 32'h0000_0E00);
      #1 rst = 1'b1;
      #1;
      wlog.delete(); wcyc.delete();
      check_eq("mid_rst_we3", 32'(we3), 32'd0);
      check_eq("mid_rst_ad3", ad3, 32'd0);
      check_eq("mid_rst_wd3", wd3, 32'd0);
      check_eq("mid_rst_pend", pend_mask, 32'd0);
      check_eq("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
      check_eq("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("post_rst_writes", 32'(wlog.size()), 32'd0);
      check_eq("post_rst_pend", pend_mask, 32'd0);
      check_eq("post_rst_alu_ready", 32'(alu_ready), 32'd1);
      check_eq("post_rst_mem_ready", 32'(mem_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the RV32I core. It merges register write requests from the ALU pipe and the load/memory unit into the single register-file write port (ad3/we3/wd3). Each source has a one-entry holding slot. Writes to x0 are dropped. The block also exports a mask of destination registers with writes still in flight, for hazard checks.

## Interface
- DATA_WIDTH, 32, data width and register-file address-port width
- ADDR_WIDTH, 5, register index width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which ALU overrides memory priority
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle when alu_valid & alu_ready
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid, mem_ready, mem_rd, mem_data: same roles as the ALU ports, for the memory unit
- ad3  out  DATA_WIDTH  write address, zero-extended from ADDR_WIDTH
- we3  out  1  write enable, registered
- wd3  out  DATA_WIDTH  write data, registered
- pend_mask  out  32  bit i set while a write to register i is pending

## Operation
- Each channel has a slot (full, rd, data).
- A handshake (valid & ready) with rd != 0 fills the slot. A handshake with rd == 0 is accepted and discarded; the slot stays as it was.
- Grant is computed combinationally from slot state and the starve counter only, never from valid inputs:
  - memory wins if its slot is full and starve < STARVE_LIMIT;
  - ALU wins if its slot is full and either the memory slot is empty or starve == STARVE_LIMIT;
  - otherwise there is no grant.
- ready = !rst & (!full | granted). A slot may be refilled in the same cycle it drains.
- On each edge:
  - with a grant, ad3/wd3 load the winner's rd/data, we3 <= 1, and the winner's slot empties unless it is refilled;
  - with no grant, we3 <= 0 and ad3/wd3 hold their values.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) when the ALU slot is full and the memory slot wins;
  - clears when the ALU is granted or its slot is empty.
- Ordering: order is preserved within a channel. A same-rd conflict across channels is resolved by grant order only. Upstream issue logic must not create cross-channel WAW conflicts.
- pend_mask is combinational. It is the OR of decode(rd) for each full slot and decode(ad3) while we3 = 1. Bit 0 is always 0.

## Timing
- Reset (asynchronous, immediate on assert):
  - slots empty, starve = 0;
  - we3 = 0, ad3 = 0, wd3 = 0, pend_mask = 0;
  - alu_ready = mem_ready = 0 while rst is high, and 1 in the first cycle after release.
- Reset mid-operation discards slot contents and any registered write. we3 drops in the same cycle.
- Latency, uncontested: handshake at edge E; we3 high in the cycle after E+1; the register file commits at edge E+2.
- Throughput: one write per cycle in total. A single channel sustains one request per cycle while it keeps winning.
- Both slots full: memory drains first. The ALU waits at most STARVE_LIMIT cycles before it is granted.
- Simultaneous handshake on both channels: both are accepted. Memory is written first, then the ALU.
- A request held with valid high and ready low must keep rd/data stable (standard valid/ready rules).

## Structure
- Shared package wb_pkg:
  - typedef wb_req_t {rd, data};
  - enum wb_src_t {WB_NONE, WB_ALU, WB_MEM};
  - default STARVE_LIMIT.
- One sub-module, wb_hold_slot: the one-entry slot holding full/rd/data, with fill, drain and x0-drop logic. It is instantiated twice.
- Grant logic, starve counter, output registers and pend_mask live in wb_arbiter.

## Test plan
- Single ALU write: rd = 5, data = 0xDEADBEEF, valid for one cycle -> we3 = 1 exactly one cycle later, ad3 = 5, wd3 = 0xDEADBEEF; pend_mask bit 5 set from the accept edge until we3 falls.
- x0 drop: mem rd = 0, data = 0x1234 -> mem_ready = 1, we3 stays 0, pend_mask stays 0.
- Simultaneous: ALU (rd 3, 0xA) and mem (rd 4, 0xB) in the same cycle -> we3 writes rd 4 / 0xB, then rd 3 / 0xA on the next cycle; both readys stay high.
- Starvation, STARVE_LIMIT = 4: mem valid every cycle, ALU rd = 7 held valid -> ALU granted on the 5th arbitration cycle, then memory resumes winning.
- Back-to-back single channel: ALU rd 1..8 on consecutive cycles -> eight consecutive we3 cycles in order, alu_ready never low.
- Reset mid-flight: both slots full and we3 = 1, assert rst -> we3, ad3, wd3 and pend_mask go to 0 immediately and readys go low; after release no stale write appears.
